// File: rtl/servo_pkg.sv
// Shared timing constants for the hobby-servo PWM generator.
// Defaults assume a 50 MHz clock and a 20 ms PWM frame.
package servo_pkg;

    localparam int CONTAGEM_MAXIMA = 1_000_000;
    localparam int BITS_CONTADOR   = 20;

    // Pulse width = 1 ms + angle/180 ms, for angles 20..160 degrees in 20 degree steps
    localparam int LARGURA_000 = 55_556;
    localparam int LARGURA_001 = 61_111;
    localparam int LARGURA_010 = 66_667;
    localparam int LARGURA_011 = 72_222;
    localparam int LARGURA_100 = 77_778;
    localparam int LARGURA_101 = 83_333;
    localparam int LARGURA_110 = 88_889;
    localparam int LARGURA_111 = 94_444;

endpackage

// File: rtl/contador_m.sv
// Free-running modulo-M up-counter with async active-low reset.
// fim flags the terminal count (q == M-1), the cycle before the wrap.
module contador_m
    import servo_pkg::*;
#(
    parameter int M = CONTAGEM_MAXIMA,
    parameter int N = BITS_CONTADOR
) (
    input  logic         clock,
    input  logic         reset,
    output logic [N-1:0] q,
    output logic         fim
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q + N'(1);
        if (q_q == ULTIMO) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign fim = (q_q == ULTIMO);

endmodule

// File: rtl/controle_servo_3.sv
// 50 Hz servo PWM: the 3-bit position selects one of eight pulse widths.
// Width is latched only at the frame boundary so pulses are never cut or stretched.
module controle_servo_3 #(
    parameter int CONTAGEM_MAXIMA = servo_pkg::CONTAGEM_MAXIMA,
    parameter int BITS_CONTADOR   = servo_pkg::BITS_CONTADOR,
    parameter int LARGURA_000     = servo_pkg::LARGURA_000,
    parameter int LARGURA_001     = servo_pkg::LARGURA_001,
    parameter int LARGURA_010     = servo_pkg::LARGURA_010,
    parameter int LARGURA_011     = servo_pkg::LARGURA_011,
    parameter int LARGURA_100     = servo_pkg::LARGURA_100,
    parameter int LARGURA_101     = servo_pkg::LARGURA_101,
    parameter int LARGURA_110     = servo_pkg::LARGURA_110,
    parameter int LARGURA_111     = servo_pkg::LARGURA_111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] posicao,
    output logic       controle,
    output logic       db_reset,
    output logic [2:0] db_posicao,
    output logic       db_controle
);

    logic [BITS_CONTADOR-1:0] conta;
    logic                     fim;
    logic [BITS_CONTADOR-1:0] largura_tab;
    logic [BITS_CONTADOR-1:0] largura_q;
    logic [BITS_CONTADOR-1:0] largura_d;
    logic                     controle_q;
    logic                     controle_d;

    contador_m #(
        .M(CONTAGEM_MAXIMA),
        .N(BITS_CONTADOR)
    ) u_contador (
        .clock(clock),
        .reset(reset),
        .q    (conta),
        .fim  (fim)
    );

    always_comb begin
        largura_tab = BITS_CONTADOR'(LARGURA_000);
        case (posicao)
            3'b000: largura_tab = BITS_CONTADOR'(LARGURA_000);
            3'b001: largura_tab = BITS_CONTADOR'(LARGURA_001);
            3'b010: largura_tab = BITS_CONTADOR'(LARGURA_010);
            3'b011: largura_tab = BITS_CONTADOR'(LARGURA_011);
            3'b100: largura_tab = BITS_CONTADOR'(LARGURA_100);
            3'b101: largura_tab = BITS_CONTADOR'(LARGURA_101);
            3'b110: largura_tab = BITS_CONTADOR'(LARGURA_110);
            3'b111: largura_tab = BITS_CONTADOR'(LARGURA_111);
        endcase
    end

    // Registered compare keeps the servo pin glitch-free; one cycle behind conta.
    always_comb begin
        largura_d  = fim ? largura_tab : largura_q;
        controle_d = (conta < largura_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            largura_q  <= BITS_CONTADOR'(LARGURA_000);
            controle_q <= 1'b0;
        end else begin
            largura_q  <= largura_d;
            controle_q <= controle_d;
        end
    end

    assign controle    = controle_q;
    assign db_reset    = reset;
    assign db_posicao  = posicao;
    assign db_controle = controle_q;

endmodule

// File: tb/tb_controle_servo_3.sv
// Self-checking bench for controle_servo_3 using a shortened 360-cycle frame.
// Expected pulse widths come from the 1 ms + angle/180 ms rule scaled to that frame.
module tb_controle_servo_3;

    localparam int CM = 360;
    localparam int BW = 9;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [2:0] posicao = 3'd0;
    logic       controle;
    logic       db_reset;
    logic [2:0] db_posicao;
    logic       db_controle;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    controle_servo_3 #(
        .CONTAGEM_MAXIMA(CM),
        .BITS_CONTADOR  (BW),
        .LARGURA_000    (20),
        .LARGURA_001    (22),
        .LARGURA_010    (24),
        .LARGURA_011    (26),
        .LARGURA_100    (28),
        .LARGURA_101    (30),
        .LARGURA_110    (32),
        .LARGURA_111    (34)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .posicao    (posicao),
        .controle   (controle),
        .db_reset   (db_reset),
        .db_posicao (db_posicao),
        .db_controle(db_controle)
    );

    // Pulse width for a position: 1 ms plus angle/180 ms, angle = 20*(p+1) degrees.
    function automatic int wid(input int p);
        int um_ms;
        um_ms = CM / 20;
        return um_ms + (um_ms * 20 * (p + 1)) / 180;
    endfunction

    // Reference: time since reset release split into frames; each frame's width
    // is the position seen on the last cycle of the previous frame.
    int unsigned n_edges  = 0;
    int          cur_w    = wid(0);
    logic        exp_ctrl = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_edges  = 0;
            cur_w    = wid(0);
            exp_ctrl = 1'b0;
        end else begin
            exp_ctrl = ((n_edges % CM) < cur_w);
            if ((n_edges % CM) == CM - 1) cur_w = wid(int'(posicao));
            n_edges++;
        end
    end

    // Called on the negedge where controle has just risen; returns the high time,
    // the frame length and how many cycles disagreed with the reference.
    task automatic measure(input int chg_c, input logic [2:0] chg_v,
                           input int rev_c, input logic [2:0] rev_v,
                           output int h, output int p, output int mism, output bit tmo);
        int c;
        c = 1; h = 0; p = 0; mism = 0; tmo = 1'b0;
        while (1) begin
            if (controle !== exp_ctrl) mism++;
            if (controle === 1'b1 && p == h) h++;
            p++;
            if (c == chg_c) posicao = chg_v;
            if (c == rev_c) posicao = rev_v;
            @(negedge clock);
            c++;
            if (controle === 1'b1 && p > h) break;
            if (c > 2 * CM) begin
                tmo = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(output bit tmo);
        logic prev;
        int   n;
        prev = controle; n = 0; tmo = 1'b0;
        while (1) begin
            @(negedge clock);
            n++;
            if (prev === 1'b0 && controle === 1'b1) break;
            prev = controle;
            if (n > 2 * CM) begin
                tmo = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int h, p, m;
        bit t;
        posicao = 3'($urandom_range(1, 7));
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (controle !== 1'b0) begin failures++; $display("FAIL reset_controle: got %b expected 0", controle); end
        checks++;
        if (db_controle !== 1'b0) begin failures++; $display("FAIL reset_db_controle: got %b expected 0", db_controle); end
        checks++;
        if (db_reset !== 1'b0) begin failures++; $display("FAIL reset_db_reset: got %b expected 0", db_reset); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (controle !== 1'b1) begin failures++; $display("FAIL reset_release_rise: got %b expected 1", controle); end
        measure(0, 3'd0, 0, 3'd0, h, p, m, t);
        checks++;
        if (h !== wid(0)) begin failures++; $display("FAIL first_frame_width: got %0d expected %0d", h, wid(0)); end
        checks++;
        if (p !== CM) begin failures++; $display("FAIL first_frame_period: got %0d expected %0d", p, CM); end
        checks++;
        if (m !== 0 || t) begin failures++; $display("FAIL first_frame_model: mismatches %0d timeout %0b expected 0 0", m, t); end
    endtask

    task automatic test_hold_pos0();
        int h, p, m;
        bit t;
        posicao = 3'd0;
        wait_rise(t);
        checks++;
        if (t) begin failures++; $display("FAIL hold_wait_rise: timeout got 1 expected 0"); end
        for (int k = 0; k < 10; k++) begin
            measure(0, 3'd0, 0, 3'd0, h, p, m, t);
            checks++;
            if (h !== wid(0)) begin failures++; $display("FAIL hold_width[%0d]: got %0d expected %0d", k, h, wid(0)); end
            checks++;
            if (p !== CM) begin failures++; $display("FAIL hold_period[%0d]: got %0d expected %0d", k, p, CM); end
            checks++;
            if (m !== 0 || t) begin failures++; $display("FAIL hold_model[%0d]: mismatches %0d timeout %0b expected 0 0", k, m, t); end
        end
    endtask

    task automatic test_sweep();
        int ord[7];
        int h, p, m;
        bit t;
        for (int i = 0; i < 7; i++) ord[i] = i + 1;
        for (int i = 6; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(0, i);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        for (int i = 0; i < 7; i++) begin
            posicao = 3'(ord[i]);
            wait_rise(t);
            checks++;
            if (t) begin failures++; $display("FAIL sweep_wait_rise[%0d]: timeout got 1 expected 0", ord[i]); end
            for (int k = 0; k < 2; k++) begin
                measure(0, 3'd0, 0, 3'd0, h, p, m, t);
                checks++;
                if (h !== wid(ord[i])) begin failures++; $display("FAIL sweep_width[%0d]: got %0d expected %0d", ord[i], h, wid(ord[i])); end
                checks++;
                if (p !== CM) begin failures++; $display("FAIL sweep_period[%0d]: got %0d expected %0d", ord[i], p, CM); end
                checks++;
                if (m !== 0 || t) begin failures++; $display("FAIL sweep_model[%0d]: mismatches %0d timeout %0b expected 0 0", ord[i], m, t); end
            end
        end
    endtask

    task automatic test_mid_change();
        int h, p, m;
        bit t;
        posicao = 3'd0;
        wait_rise(t);
        measure($urandom_range(3, 15), 3'd7, 0, 3'd0, h, p, m, t);
        checks++;
        if (h !== wid(0)) begin failures++; $display("FAIL mid_change_current: got %0d expected %0d", h, wid(0)); end
        checks++;
        if (p !== CM || m !== 0 || t) begin failures++; $display("FAIL mid_change_frame: period %0d mism %0d tmo %0b expected %0d 0 0", p, m, t, CM); end
        measure(0, 3'd0, 0, 3'd0, h, p, m, t);
        checks++;
        if (h !== wid(7)) begin failures++; $display("FAIL mid_change_next: got %0d expected %0d", h, wid(7)); end
    endtask

    task automatic test_revert();
        int h, p, m, ca, cr;
        bit t;
        logic [2:0] p0, x;
        for (int r = 0; r < 3; r++) begin
            p0 = 3'($urandom_range(0, 7));
            x  = 3'((int'(p0) + $urandom_range(1, 7)) % 8);
            posicao = p0;
            wait_rise(t);
            ca = $urandom_range(2, 200);
            cr = $urandom_range(ca + 1, CM - 5);
            measure(ca, x, cr, p0, h, p, m, t);
            checks++;
            if (h !== wid(p0) || m !== 0 || t) begin failures++; $display("FAIL revert_current[%0d]: got %0d mism %0d expected %0d", r, h, m, wid(p0)); end
            measure(0, 3'd0, 0, 3'd0, h, p, m, t);
            checks++;
            if (h !== wid(p0)) begin failures++; $display("FAIL revert_next[%0d]: got %0d expected %0d", r, h, wid(p0)); end
        end
    endtask

    task automatic test_async_reset();
        int h, p, m;
        bit t;
        logic [2:0] pn;
        posicao = 3'd0;
        wait_rise(t);
        repeat ($urandom_range(2, 10)) @(negedge clock);
        checks++;
        if (controle !== 1'b1) begin failures++; $display("FAIL async_pre_high: got %b expected 1", controle); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (controle !== 1'b0) begin failures++; $display("FAIL async_drop: got %b expected 0", controle); end
        checks++;
        if (db_controle !== 1'b0 || db_reset !== 1'b0) begin failures++; $display("FAIL async_debug: db_controle %b db_reset %b expected 0 0", db_controle, db_reset); end
        repeat (2) @(negedge clock);
        pn = 3'($urandom_range(1, 7));
        posicao = pn;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (controle !== 1'b1) begin failures++; $display("FAIL async_restart_rise: got %b expected 1", controle); end
        measure(0, 3'd0, 0, 3'd0, h, p, m, t);
        checks++;
        if (h !== wid(0) || p !== CM || m !== 0 || t) begin failures++; $display("FAIL async_restart_frame: width %0d period %0d mism %0d expected %0d %0d 0", h, p, m, wid(0), CM); end
        measure(0, 3'd0, 0, 3'd0, h, p, m, t);
        checks++;
        if (h !== wid(pn)) begin failures++; $display("FAIL async_second_frame: got %0d expected %0d", h, wid(pn)); end
    endtask

    task automatic test_debug();
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            #($urandom_range(1, 3));
            posicao = 3'(i);
            if ($urandom_range(0, 3) == 0) reset = ~reset;
            #1;
            checks++;
            if (db_posicao !== posicao) begin failures++; $display("FAIL dbg_posicao[%0d]: got %0d expected %0d", i, db_posicao, posicao); end
            checks++;
            if (db_reset !== reset) begin failures++; $display("FAIL dbg_reset[%0d]: got %b expected %b", i, db_reset, reset); end
            checks++;
            if (db_controle !== controle) begin failures++; $display("FAIL dbg_controle[%0d]: got %b expected %b", i, db_controle, controle); end
            if (reset === 1'b0) begin
                checks++;
                if (controle !== 1'b0) begin failures++; $display("FAIL dbg_reset_controle[%0d]: got %b expected 0", i, controle); end
            end
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_hold_pos0();
        test_sweep();
        test_mid_change();
        test_revert();
        test_async_reset();
        test_debug();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_servo_3.md
Name: controle_servo_3

Overview:
PWM generator for a hobby servo. It produces a 50 Hz control signal (20 ms period at a 50 MHz clock). The high-pulse width is selected by a 3-bit position input and maps to eight angles from 20° to 160° in 20° steps. It sits between the system's position logic and the servo pin, and exposes debug copies of its inputs and output for LEDs and the logic analyser.

Parameters:
- CONTAGEM_MAXIMA, 1_000_000: PWM period in clock cycles (20 ms at 50 MHz).
- BITS_CONTADOR, 20: counter width; must satisfy 2^BITS_CONTADOR >= CONTAGEM_MAXIMA.
- LARGURA_000..LARGURA_111: high-pulse widths in cycles, default 55_556, 61_111, 66_667, 72_222, 77_778, 83_333, 88_889, 94_444. Each is 1 ms + angle/180 ms, for angles 20/40/60/80/100/120/140/160°.

Ports:
- clock, in, 1: system clock, 50 MHz, rising-edge.
- reset, in, 1: asynchronous, active-low reset (0 = reset).
- posicao, in, 3: requested position index, 0..7.
- controle, out, 1: PWM signal to the servo.
- db_reset, out, 1: direct copy of reset.
- db_posicao, out, 3: direct copy of posicao.
- db_controle, out, 1: copy of controle.

Behaviour:
- One clock domain. All registers clear asynchronously while reset=0 and update on the rising clock edge while reset=1.
- Period counter `conta`:
  - Reset value 0.
  - Increments by 1 each cycle. When conta == CONTAGEM_MAXIMA-1 it wraps to 0 on the next edge.
  - Free-running; no enable.
- Width lookup: combinational table from posicao to width in cycles, using the LARGURA_xxx parameters (000→55_556 … 111→94_444). All 8 codes are valid; there is no default/illegal case.
- Width register `largura`:
  - Reset value LARGURA_000.
  - Loads the lookup result only on the edge where conta == CONTAGEM_MAXIMA-1, so changes take effect at the next period start.
  - A posicao change mid-period never truncates or extends the current pulse. Changes that revert before the period boundary have no effect.
- Output register `controle`:
  - Reset value 0.
  - Each edge: controle <= (conta < largura), using the pre-edge values.
  - Result: high for exactly largura consecutive cycles per period, then low for CONTAGEM_MAXIMA-largura cycles. Output is one-cycle delayed relative to the counter and is glitch-free.
- After reset release: the first rising edge sees conta=0, so controle rises on that edge. The first period uses LARGURA_000 regardless of posicao.
- Reset asserted mid-pulse: controle drops to 0 immediately (asynchronously), conta returns to 0 and largura to LARGURA_000.
- Debug outputs are pure wires, no registers: db_reset=reset, db_posicao=posicao, db_controle=controle.
- Arithmetic: compare is unsigned, BITS_CONTADOR wide. Widths are zero-extended to BITS_CONTADOR.

Decomposition:
- Shared package servo_pkg holds:
  - CONTAGEM_MAXIMA and BITS_CONTADOR;
  - the eight LARGURA constants, or an array indexed by position.
- One natural sub-module, contador_m: a modulo-M up-counter with async active-low reset. Its outputs are the count Q and a terminal-count flag fim (Q == M-1); fim drives the largura load.
- Lookup, width register and comparator stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles → controle=0, db_controle=0, db_reset=0. Release → controle high on the next edge.
- posicao=000 held 200 ms → period exactly 1_000_000 cycles (20 ms), high time 55_556 cycles (≈1.111 ms), 10 periods observed.
- Sweep posicao 001..111, 200 ms each → high times 61_111, 66_667, 72_222, 77_778, 83_333, 88_889, 94_444 cycles. The period stays 1_000_000 for every code.
- Mid-period change: set posicao 000→111 while controle is high at conta≈30_000 → the current pulse still ends at 55_556 cycles; the next pulse is 94_444 cycles.
- Async reset mid-pulse: drive reset=0 between clock edges at conta≈40_000 → controle falls before the next edge. After release, timing restarts from conta=0 with width 55_556.
- Debug passthrough: toggle posicao through all 8 codes and reset → db_posicao==posicao, db_reset==reset and db_controle==controle at all times.
